// File: rtl/lanzones_pkg.sv
// lanzones_pkg: shared state/owner encodings and memory port widths for the lanzones arbiter
package lanzones_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int DW = 32;
  localparam int SW = 4;
endpackage

// File: rtl/lanzones_rr_pick.sv
// lanzones_rr_pick: 2-way picker; reqs[0]=fetch, reqs[1]=data, last=previous owner, winner=chosen port
module lanzones_rr_pick
  import lanzones_pkg::*;
#(
  parameter bit DPRIO = 1'b0
) (
  input  logic [1:0] reqs,
  input  owner_t     last,
  output owner_t     winner
);
  always_comb winner = (reqs == 2'b11) ? ((DPRIO || last == OWN_I) ? OWN_D : OWN_I)
                                       : (reqs[1] ? OWN_D : OWN_I);
endmodule

// File: rtl/lanzones_mem_arbiter.sv
// lanzones_mem_arbiter: fetch (i_*) and load/store (d_*) ports share one memory port (R*), one access at a time, with watchdog abort (err)
module lanzones_mem_arbiter
  import lanzones_pkg::*;
#(
  parameter bit DPRIO   = 1'b0,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [DW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvld,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [SW-1:0] d_strb,
  input  logic [DW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvld,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          RRdy,
  output logic [DW-1:0] RAddr,
  output logic          RWEn,
  output logic [SW-1:0] RWStrobe,
  output logic [DW-1:0] RWData,
  input  logic          RVld,
  input  logic [DW-1:0] RData
);
  state_t state_q, state_d;
  owner_t owner_q, owner_d, last_q, last_d, win;
  logic [7:0] wd_q, wd_d;
  logic we_q, we_d, rrdy_q, rrdy_d, rwen_q, rwen_d, i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic [DW-1:0] raddr_q, raddr_d, rwdata_q, rwdata_d;
  logic [SW-1:0] rwstrb_q, rwstrb_d;
  logic tmo, done, launch;
  lanzones_rr_pick #(.DPRIO(DPRIO)) u_pick (.reqs({d_req, i_req}), .last(last_q), .winner(win));
  // rst gates completion so an access dropped by reset never reports rvld
  assign tmo    = !rst && state_q == BUSY && wd_q == 8'(TIMEOUT - 1);
  assign done   = !rst && state_q == BUSY && (RVld || tmo);
  assign launch = state_q == IDLE || done;
  assign i_rvld  = done && owner_q == OWN_I;
  assign d_rvld  = done && owner_q == OWN_D;
  assign err     = tmo;
  assign i_rdata = (i_rvld && !tmo) ? RData : '0;
  assign d_rdata = (d_rvld && !tmo && !we_q) ? RData : '0;
  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign RRdy     = rrdy_q;
  assign RAddr    = raddr_q;
  assign RWEn     = rwen_q;
  assign RWStrobe = rwstrb_q;
  assign RWData   = rwdata_q;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    wd_d     = (state_q == BUSY && !RVld && wd_q != 8'hff) ? wd_q + 8'd1 : wd_q;
    rrdy_d   = rrdy_q;
    raddr_d  = raddr_q;
    rwstrb_d = rwstrb_q;
    rwdata_d = rwdata_q;
    rwen_d   = 1'b0;
    i_gnt_d  = 1'b0;
    d_gnt_d  = 1'b0;
    if (launch && (i_req || d_req)) begin
      state_d  = BUSY;
      owner_d  = win;
      last_d   = win;
      we_d     = win == OWN_D && d_we;
      wd_d     = '0;
      rrdy_d   = 1'b1;
      raddr_d  = win == OWN_D ? d_addr : i_addr;
      rwen_d   = we_d;
      rwstrb_d = we_d ? d_strb : '0;
      rwdata_d = we_d ? d_wdata : '0;
      i_gnt_d  = win == OWN_I;
      d_gnt_d  = win == OWN_D;
    end else if (done) begin
      state_d  = IDLE;
      we_d     = 1'b0;
      wd_d     = '0;
      rrdy_d   = 1'b0;
      raddr_d  = '0;
      rwstrb_d = '0;
      rwdata_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      last_q   <= OWN_D;
      we_q     <= 1'b0;
      wd_q     <= '0;
      rrdy_q   <= 1'b0;
      raddr_q  <= '0;
      rwstrb_q <= '0;
      rwdata_q <= '0;
      rwen_q   <= 1'b0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      wd_q     <= wd_d;
      rrdy_q   <= rrdy_d;
      raddr_q  <= raddr_d;
      rwstrb_q <= rwstrb_d;
      rwdata_q <= rwdata_d;
      rwen_q   <= rwen_d;
      i_gnt_q  <= i_gnt_d;
      d_gnt_q  <= d_gnt_d;
    end
  end
endmodule
